// File: rtl/verificador_nonce_pkg.sv
// Shared widths, FSM encoding and the micro-hash round used by the verifier and its hash core.
package verificador_nonce_pkg;

    localparam int unsigned PAYLOAD_W   = 96;
    localparam int unsigned NONCE_W     = 32;
    localparam int unsigned HASH_W      = 24;
    localparam int unsigned TARGET_W    = 8;
    localparam int unsigned MSG_W       = PAYLOAD_W + NONCE_W;
    localparam int unsigned MSG_BYTES   = MSG_W / 8;
    localparam int unsigned TIMEOUT_DEF = 255;

    localparam logic [HASH_W-1:0] HASH_IV = 24'h6a09e6;
    localparam logic [HASH_W-1:0] HASH_K  = 24'h3779b9;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StLoad = 3'd1,
        StHash = 3'd2,
        StCmp  = 3'd3,
        StDone = 3'd4
    } state_e;

    // One byte per round: add-mix the byte in, then rotate-left-5 folded with a right shift.
    function automatic logic [HASH_W-1:0] hash_round(input logic [HASH_W-1:0] h,
                                                     input logic [7:0]        b);
        logic [HASH_W-1:0] t;
        t = h + {b, b ^ h[7:0], b};
        return {t[18:0], t[23:19]} ^ (t >> 7) ^ HASH_K;
    endfunction

    // Both upper hash bytes must be strictly below the target (unsigned).
    function automatic logic target_pass(input logic [HASH_W-1:0]   h,
                                         input logic [TARGET_W-1:0] t);
        return (h[23:16] < t) && (h[15:8] < t);
    endfunction

endpackage

// File: rtl/micro_hash_core.sv
// Iterative micro-hash: consumes {payload, nonce} one byte per cycle, MSB first,
// and pulses core_done for one cycle once the final hash is on the output.
module micro_hash_core
    import verificador_nonce_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              core_start,
    input  logic [MSG_W-1:0]  msg,
    output logic              core_done,
    output logic [HASH_W-1:0] hash
);

    logic [MSG_W-1:0]  msg_q;
    logic [HASH_W-1:0] h_q;
    logic [3:0]        cnt_q;
    logic              run_q;
    logic              done_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            msg_q  <= '0;
            h_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (core_start) begin
                msg_q <= msg;
                h_q   <= HASH_IV;
                cnt_q <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                h_q   <= hash_round(h_q, msg_q[MSG_W-1 -: 8]);
                msg_q <= {msg_q[MSG_W-9:0], 8'h00};
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q == 4'(MSG_BYTES - 1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign core_done = done_q;
    assign hash      = h_q;

endmodule

// File: rtl/verificador_nonce.sv
// Nonce verifier: recomputes the micro-hash of a captured {payload, nonce} and checks it
// against the claimed hash and the difficulty target, with a bounded wait on the core.
module verificador_nonce
    import verificador_nonce_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic [NONCE_W-1:0]   nonce,
    input  logic [HASH_W-1:0]    hash_in,
    input  logic [TARGET_W-1:0]  target,
    output logic                 busy,
    output logic                 terminado,
    output logic                 valido,
    output logic                 hash_ok,
    output logic                 target_ok,
    output logic                 timeout,
    output logic [HASH_W-1:0]    hashCalc
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e state_q, state_d;

    logic [PAYLOAD_W-1:0] payload_q;
    logic [NONCE_W-1:0]   nonce_q;
    logic [HASH_W-1:0]    hash_in_q;
    logic [TARGET_W-1:0]  target_q;
    logic [CNT_W-1:0]     cnt_q;

    logic              busy_q, terminado_q, valido_q, hash_ok_q, target_ok_q, timeout_q;
    logic [HASH_W-1:0] hash_calc_q;

    logic              core_start;
    logic              core_done;
    logic [HASH_W-1:0] core_hash;
    logic              cnt_expired;

    assign core_start  = (state_q == StLoad);
    assign cnt_expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    micro_hash_core u_core (
        .clk        (clk),
        .reset      (reset),
        .core_start (core_start),
        .msg        ({payload_q, nonce_q}),
        .core_done  (core_done),
        .hash       (core_hash)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StLoad;
            StLoad:  state_d = StHash;
            StHash:  if (core_done || cnt_expired) state_d = StCmp;
            StCmp:   state_d = StDone;
            StDone:  if (!start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            payload_q   <= '0;
            nonce_q     <= '0;
            hash_in_q   <= '0;
            target_q    <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            terminado_q <= 1'b0;
            valido_q    <= 1'b0;
            hash_ok_q   <= 1'b0;
            target_ok_q <= 1'b0;
            timeout_q   <= 1'b0;
            hash_calc_q <= '0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    // Previous verdict stays visible in IDLE until the next capture.
                    if (start) begin
                        payload_q   <= payload;
                        nonce_q     <= nonce;
                        hash_in_q   <= hash_in;
                        target_q    <= target;
                        busy_q      <= 1'b1;
                        valido_q    <= 1'b0;
                        hash_ok_q   <= 1'b0;
                        target_ok_q <= 1'b0;
                        timeout_q   <= 1'b0;
                        hash_calc_q <= '0;
                    end
                end
                StLoad: cnt_q <= '0;
                StHash: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (core_done) begin
                        hash_calc_q <= core_hash;
                    end else if (cnt_expired) begin
                        timeout_q   <= 1'b1;
                        hash_calc_q <= '0;
                    end
                end
                StCmp: begin
                    hash_ok_q   <= (hash_calc_q == hash_in_q);
                    target_ok_q <= target_pass(hash_in_q, target_q);
                    valido_q    <= (hash_calc_q == hash_in_q) && target_pass(hash_in_q, target_q)
                                   && !timeout_q;
                    busy_q      <= 1'b0;
                    terminado_q <= 1'b1;
                end
                StDone: if (!start) terminado_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy      = busy_q;
    assign terminado = terminado_q;
    assign valido    = valido_q;
    assign hash_ok   = hash_ok_q;
    assign target_ok = target_ok_q;
    assign timeout   = timeout_q;
    assign hashCalc  = hash_calc_q;

endmodule

// File: tb/tb_verificador_nonce.sv
// Self-checking bench for verificador_nonce against an arithmetic reference model of the
// micro-hash and verdict rules; a second instance with a short TIMEOUT exercises the abort path.
module tb_verificador_nonce;

    localparam int unsigned TO_SMALL = 8;
    localparam logic [95:0] GP = 96'h397d9f2f40ca9e6c6b1f3324;

    logic        clk = 1'b0;
    logic        reset, start, start2;
    logic [95:0] payload;
    logic [31:0] nonce;
    logic [23:0] hash_in;
    logic [7:0]  target;

    logic        busy, terminado, valido, hash_ok, target_ok, timeout;
    logic [23:0] hash_calc;
    logic        busy_t, terminado_t, valido_t, hash_ok_t, target_ok_t, timeout_t;
    logic [23:0] hash_calc_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] g_nonce;
    logic [23:0] g_hash;

    always #5 clk = ~clk;

    verificador_nonce #(.TIMEOUT(255)) dut (
        .clk(clk), .reset(reset), .start(start), .payload(payload), .nonce(nonce),
        .hash_in(hash_in), .target(target), .busy(busy), .terminado(terminado),
        .valido(valido), .hash_ok(hash_ok), .target_ok(target_ok), .timeout(timeout),
        .hashCalc(hash_calc)
    );

    verificador_nonce #(.TIMEOUT(TO_SMALL)) dut_to (
        .clk(clk), .reset(reset), .start(start2), .payload(payload), .nonce(nonce),
        .hash_in(hash_in), .target(target), .busy(busy_t), .terminado(terminado_t),
        .valido(valido_t), .hash_ok(hash_ok_t), .target_ok(target_ok_t), .timeout(timeout_t),
        .hashCalc(hash_calc_t)
    );

    // Reference micro-hash written as plain 32-bit arithmetic over the 16 message bytes.
    function automatic logic [23:0] model_hash(input logic [95:0] p, input logic [31:0] n);
        logic [127:0] m;
        int unsigned  h, b, t, r;
        m = {p, n};
        h = 32'h6a09e6;
        for (int i = 0; i < 16; i++) begin
            b = 32'(m[127 - 8*i -: 8]);
            t = (h + (b << 16) + ((b ^ (h & 32'hff)) << 8) + b) & 32'hffffff;
            r = ((t << 5) | (t >> 19)) & 32'hffffff;
            h = r ^ (t >> 7) ^ 32'h3779b9;
        end
        return h[23:0];
    endfunction

    function automatic bit model_target(input logic [23:0] h, input logic [7:0] t);
        return (int'(h[23:16]) < int'(t)) && (int'(h[15:8]) < int'(t));
    endfunction

    // Drives one request; returns the number of cycles from start to terminado.
    task automatic run_check(input logic [95:0] p, input logic [31:0] n, input logic [23:0] h,
                             input logic [7:0] t, input bit hold, output int lat);
        @(negedge clk);
        payload = p; nonce = n; hash_in = h; target = t; start = 1'b1; lat = 0;
        @(negedge clk);
        lat = 1;
        if (!hold) start = 1'b0;
        payload = {$urandom, $urandom, $urandom};
        nonce = $urandom; hash_in = 24'($urandom); target = 8'($urandom);
        while (terminado !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (terminado !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_terminado: terminado=%b after %0d cycles, required 1", terminado, lat);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; start2 = 1'b0;
        payload = '0; nonce = '0; hash_in = '0; target = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({busy, terminado, valido, hash_ok, target_ok, timeout, hash_calc} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b/%b/%b/%b/%b/%b/%h, required all 0",
                     busy, terminado, valido, hash_ok, target_ok, timeout, hash_calc);
        end
    endtask

    task automatic test_golden;
        bit found;
        logic [31:0] n0, n;
        logic [23:0] h;
        int lat;
        found = 0; n0 = $urandom;
        for (int i = 0; i < 400000 && !found; i++) begin
            n = n0 + 32'(i);
            h = model_hash(GP, n);
            if (model_target(h, 8'h0a)) begin
                found = 1; g_nonce = n; g_hash = h;
            end
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL golden_search: no nonce found, required one");
        end
        run_check(GP, g_nonce, g_hash, 8'h0a, 1'b0, lat);
        n_checks += 6;
        if (hash_ok !== 1'b1)   begin n_fail++; $display("FAIL golden_hash_ok: got %b, required 1", hash_ok); end
        if (target_ok !== 1'b1) begin n_fail++; $display("FAIL golden_target_ok: got %b, required 1", target_ok); end
        if (valido !== 1'b1)    begin n_fail++; $display("FAIL golden_valido: got %b, required 1", valido); end
        if (hash_calc !== g_hash) begin n_fail++; $display("FAIL golden_hashcalc: got %h, required %h", hash_calc, g_hash); end
        if (busy !== 1'b0 || timeout !== 1'b0) begin n_fail++; $display("FAIL golden_busy_timeout: got %b/%b, required 0/0", busy, timeout); end
        if (lat != 20) begin n_fail++; $display("FAIL golden_latency: got %0d, required 20", lat); end
    endtask

    task automatic test_bad_hash;
        int lat;
        run_check(GP, g_nonce, g_hash ^ 24'h1, 8'h0a, 1'b0, lat);
        n_checks += 3;
        if (hash_ok !== 1'b0)   begin n_fail++; $display("FAIL badhash_hash_ok: got %b, required 0", hash_ok); end
        if (valido !== 1'b0)    begin n_fail++; $display("FAIL badhash_valido: got %b, required 0", valido); end
        if (target_ok !== 1'b1) begin n_fail++; $display("FAIL badhash_target_ok: got %b, required 1", target_ok); end
    endtask

    task automatic test_bad_nonce;
        int lat;
        logic [23:0] exp_h;
        exp_h = model_hash(GP, g_nonce + 32'd1);
        run_check(GP, g_nonce + 32'd1, g_hash, 8'h0a, 1'b0, lat);
        n_checks += 3;
        if (hash_calc !== exp_h) begin n_fail++; $display("FAIL badnonce_hashcalc: got %h, required %h", hash_calc, exp_h); end
        if (hash_ok !== 1'(exp_h == g_hash)) begin n_fail++; $display("FAIL badnonce_hash_ok: got %b, required %b", hash_ok, exp_h == g_hash); end
        if (valido !== 1'b0) begin n_fail++; $display("FAIL badnonce_valido: got %b, required 0", valido); end
    endtask

    task automatic test_target_zero;
        int lat;
        run_check(GP, g_nonce, g_hash, 8'h00, 1'b0, lat);
        n_checks += 3;
        if (target_ok !== 1'b0) begin n_fail++; $display("FAIL tzero_target_ok: got %b, required 0", target_ok); end
        if (valido !== 1'b0)    begin n_fail++; $display("FAIL tzero_valido: got %b, required 0", valido); end
        if (hash_ok !== 1'b1)   begin n_fail++; $display("FAIL tzero_hash_ok: got %b, required 1", hash_ok); end
    endtask

    task automatic test_target_bounds;
        logic [23:0] hs [4];
        logic [7:0]  ts [4];
        int lat;
        hs[0] = 24'hfefe00; ts[0] = 8'hff;
        hs[1] = 24'hff0000; ts[1] = 8'hff;
        hs[2] = 24'h10200f; ts[2] = 8'h20;
        hs[3] = 24'h1f1fff; ts[3] = 8'h20;
        for (int i = 0; i < 4; i++) begin
            run_check(GP, g_nonce, hs[i], ts[i], 1'b0, lat);
            n_checks++;
            if (target_ok !== model_target(hs[i], ts[i])) begin
                n_fail++;
                $display("FAIL bounds_target_ok[%0d]: got %b, required %b", i, target_ok,
                         model_target(hs[i], ts[i]));
            end
        end
    endtask

    task automatic test_reset_mid_hash;
        bit seen;
        int lat;
        @(negedge clk);
        payload = GP; nonce = g_nonce; hash_in = g_hash; target = 8'h0a; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({busy, terminado, valido, hash_ok, target_ok, timeout, hash_calc} !== 30'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got %b/%b/%b/%b/%b/%b/%h, required all 0",
                     busy, terminado, valido, hash_ok, target_ok, timeout, hash_calc);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (terminado === 1'b1 || busy === 1'b1) seen = 1;
        end
        n_checks++;
        if (seen) begin n_fail++; $display("FAIL midreset_idle: activity seen after reset, required none"); end
        run_check(GP, g_nonce, g_hash, 8'h0a, 1'b0, lat);
        n_checks++;
        if (valido !== 1'b1) begin n_fail++; $display("FAIL midreset_recheck_valido: got %b, required 1", valido); end
    endtask

    task automatic test_hold_start;
        int lat, bad;
        logic [95:0] p;
        logic [31:0] n;
        logic [23:0] h;
        run_check(GP, g_nonce, g_hash, 8'h0a, 1'b1, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (terminado !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL hold_no_retrigger: %0d bad cycles, required 0", bad); end
        start = 1'b0;
        @(negedge clk);
        n_checks++;
        if (terminado !== 1'b0) begin n_fail++; $display("FAIL hold_release: terminado=%b, required 0", terminado); end
        p = {$urandom, $urandom, $urandom}; n = $urandom; h = model_hash(p, n);
        run_check(p, n, h, 8'hff, 1'b0, lat);
        n_checks += 2;
        if (hash_calc !== h) begin n_fail++; $display("FAIL hold_fresh_hashcalc: got %h, required %h", hash_calc, h); end
        if (valido !== model_target(h, 8'hff)) begin n_fail++; $display("FAIL hold_fresh_valido: got %b, required %b", valido, model_target(h, 8'hff)); end
    endtask

    task automatic test_timeout;
        int lat;
        @(negedge clk);
        payload = GP; nonce = g_nonce; hash_in = g_hash; target = 8'h0a; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0; lat = 1;
        while (terminado_t !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_checks += 6;
        if (terminado_t !== 1'b1) begin n_fail++; $display("FAIL to_terminado: got %b, required 1", terminado_t); end
        if (timeout_t !== 1'b1)   begin n_fail++; $display("FAIL to_timeout: got %b, required 1", timeout_t); end
        if (valido_t !== 1'b0)    begin n_fail++; $display("FAIL to_valido: got %b, required 0", valido_t); end
        if (hash_calc_t !== 24'h0) begin n_fail++; $display("FAIL to_hashcalc: got %h, required 0", hash_calc_t); end
        if (hash_ok_t !== 1'(g_hash == 24'h0) || target_ok_t !== 1'b1) begin
            n_fail++;
            $display("FAIL to_flags: hash_ok=%b target_ok=%b, required %b/1", hash_ok_t, target_ok_t, g_hash == 24'h0);
        end
        if (lat != 3 + TO_SMALL) begin n_fail++; $display("FAIL to_latency: got %0d, required %0d", lat, 3 + TO_SMALL); end
    endtask

    task automatic test_random;
        logic [95:0] p;
        logic [31:0] n;
        logic [23:0] h, exp_h;
        logic [7:0]  t;
        bit          e_hok, e_tok;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            p = {$urandom, $urandom, $urandom}; n = $urandom;
            exp_h = model_hash(p, n);
            t = (i % 3 == 0) ? 8'hff : 8'($urandom);
            case ($urandom_range(0, 2))
                0:       h = exp_h;
                1:       h = exp_h ^ (24'h1 << $urandom_range(0, 23));
                default: h = 24'($urandom);
            endcase
            e_hok = (exp_h == h);
            e_tok = model_target(h, t);
            run_check(p, n, h, t, 1'b0, lat);
            n_checks++;
            if (hash_calc !== exp_h || hash_ok !== e_hok || target_ok !== e_tok
                || valido !== (e_hok && e_tok) || timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL random[%0d]: got calc=%h hok=%b tok=%b val=%b to=%b, required %h %b %b %b 0",
                         i, hash_calc, hash_ok, target_ok, valido, timeout,
                         exp_h, e_hok, e_tok, e_hok && e_tok);
            end
        end
    endtask

    initial begin
        test_reset;
        test_golden;
        test_bad_hash;
        test_bad_nonce;
        test_target_zero;
        test_target_bounds;
        test_reset_mid_hash;
        test_hold_start;
        test_timeout;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
